// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the M stage.
// Services one word access at a time against an internal RAM with a
// fixed access latency. The pipeline is held with stallM until the
// response cycle, in which doneM is high and the M stage may advance.
module dmem_responder #(
    parameter int AW_WORDS = 10,   // log2 of RAM depth in 32-bit words
    parameter int LATENCY  = 2     // access latency in cycles, 1..15
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        memwriteM,
    input  logic        memtoregM,
    input  logic [31:0] addrM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        doneM,
    output logic        misalignM
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int          DEPTH  = 1 << AW_WORDS;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_op_wr;
    logic                  r_op_rd;
    logic [AW_WORDS-1:0]   r_idx;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [0:DEPTH-1];

    logic                  w_req;
    logic                  w_aligned;
    logic                  w_accept;
    logic                  w_commit;
    logic                  w_acc_wr;
    logic                  w_acc_rd;
    logic [AW_WORDS-1:0]   w_acc_idx;
    logic [31:0]           w_acc_data;
    logic [AW_WORDS-1:0]   w_in_idx;
    logic                  w_unused_addr;

    assign w_req     = memwriteM | memtoregM;
    assign w_aligned = (addrM[1:0] == 2'b00);
    assign w_in_idx  = addrM[AW_WORDS+1:2];
    // Upper address bits are deliberately dropped: accesses wrap modulo RAM size.
    assign w_unused_addr = ^addrM[31:AW_WORDS+2];

    // An aligned request seen in IDLE starts an access; misaligned ones are dropped.
    assign w_accept = (r_state == S_IDLE) & w_req & w_aligned;

    // With LATENCY=1 the commit edge is the accept edge, so the latches are not
    // yet loaded; take the operation straight from the inputs in that case.
    assign w_acc_wr   = (r_state == S_IDLE) ? memwriteM  : r_op_wr;
    assign w_acc_rd   = (r_state == S_IDLE) ? memtoregM  : r_op_rd;
    assign w_acc_idx  = (r_state == S_IDLE) ? w_in_idx   : r_idx;
    assign w_acc_data = (r_state == S_IDLE) ? writedataM : r_wdata;

    // The access takes effect on the edge that enters RESP. Gating with rst keeps
    // an edge that arrives while reset is held from writing the RAM.
    assign w_commit = rst & (w_next == S_RESP) & (r_state != S_RESP);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (LATENCY > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output logic; all strobes are forced low while reset is asserted
    always_comb begin
        stallM    = rst & (w_accept | (r_state == S_WAIT));
        doneM     = rst & (r_state == S_RESP);
        misalignM = rst & (r_state == S_IDLE) & w_req & ~w_aligned;
    end

    // Request latches and latency counter; inputs are ignored after acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 4'd0;
            r_op_wr <= 1'b0;
            r_op_rd <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_cnt   <= LAT_M1;
            r_op_wr <= memwriteM;
            r_op_rd <= memtoregM;
            r_idx   <= w_in_idx;
            r_wdata <= writedataM;
        end else if (r_state == S_WAIT) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Load data register: updated only by a completing load (or cleared by a
    // simultaneous read+write, which is treated as a store)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'd0;
        end else if (w_commit) begin
            if (w_acc_wr && w_acc_rd) begin
                r_rdata <= 32'd0;
            end else if (!w_acc_wr) begin
                r_rdata <= r_mem[w_acc_idx];
            end
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_commit && w_acc_wr) begin
            r_mem[w_acc_idx] <= w_acc_data;
        end
    end

    assign readdataM = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) driven by a
// common access task; a reference RAM feeds expected load data into a
// scoreboard queue that is drained on each doneM.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  mw;
    logic [2:0]  mr;
    logic [31:0] addr [0:2];
    logic [31:0] wd   [0:2];
    wire  [31:0] rdata [0:2];
    wire  [2:0]  stall;
    wire  [2:0]  done;
    wire  [2:0]  mis;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        dmem_responder #(.AW_WORDS(10), .LATENCY(L)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .memwriteM  (mw[g]),
            .memtoregM  (mr[g]),
            .addrM      (addr[g]),
            .writedataM (wd[g]),
            .readdataM  (rdata[g]),
            .stallM     (stall[g]),
            .doneM      (done[g]),
            .misalignM  (mis[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl    [3][1024];
    logic [31:0] mdl_rd [3];
    logic [31:0] sb [$];

    function automatic int lat(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one access on instance k. Called just after a rising edge; returns
    // just after the rising edge that ends the access, with inputs idle.
    task automatic access(int k, bit w, bit r, logic [31:0] a, logic [31:0] d, string tag);
        int          L    = lat(k);
        bit          ali  = (a[1:0] == 2'b00);
        logic [9:0]  idx  = a[11:2];
        logic [31:0] spat = 0;
        logic [31:0] dpat = 0;
        int          cyc  = 0;
        bit          mseen = 0;
        logic [31:0] ev;
        if (ali) begin
            if (w) begin
                mdl[k][idx] = d;
                ev = r ? 32'd0 : mdl_rd[k];
            end else begin
                ev = mdl[k][idx];
            end
            mdl_rd[k] = ev;
            sb.push_back(ev);
        end
        mw[k] = w; mr[k] = r; addr[k] = a; wd[k] = d;
        forever begin
            @(negedge clk);
            cyc++;
            spat = {spat[30:0], stall[k]};
            dpat = {dpat[30:0], done[k]};
            if (mis[k]) mseen = 1;
            if (done[k]) begin
                if (sb.size() > 0) begin
                    ev = sb.pop_front();
                    chk({tag, " rdata"}, rdata[k], ev);
                end else begin
                    chk({tag, " unexpected done"}, 32'd1, 32'd0);
                end
            end
            if (!stall[k] || cyc >= 40) break;
            @(posedge clk); #1;
        end
        if (ali) begin
            chk({tag, " cycles"}, 32'(cyc), 32'(L + 1));
            chk({tag, " stall pattern"}, spat, ((32'd1 << L) - 32'd1) << 1);
            chk({tag, " done pattern"}, dpat, 32'd1);
            chk({tag, " misalign"}, {31'd0, mseen}, 32'd0);
        end else begin
            chk({tag, " cycles"}, 32'(cyc), 32'd1);
            chk({tag, " stall pattern"}, spat, 32'd0);
            chk({tag, " done pattern"}, dpat, 32'd0);
            chk({tag, " misalign"}, {31'd0, mseen}, 32'd1);
            chk({tag, " rdata held"}, rdata[k], mdl_rd[k]);
        end
        @(posedge clk); #1;
        mw[k] = 0; mr[k] = 0;
    endtask

    task automatic chk_idle(int k, string tag);
        chk({tag, " rdata"}, rdata[k], mdl_rd[k]);
        chk({tag, " stall"}, {31'd0, stall[k]}, 32'd0);
        chk({tag, " done"},  {31'd0, done[k]},  32'd0);
        chk({tag, " mis"},   {31'd0, mis[k]},   32'd0);
    endtask

    initial begin
        rst = 3'b000; mw = 3'b000; mr = 3'b000;
        for (int k = 0; k < 3; k++) begin
            addr[k] = 0; wd[k] = 0; mdl_rd[k] = 0;
        end

        // Reset and idle outputs
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) chk_idle(k, "in reset");
        end
        @(posedge clk); #1;
        rst = 3'b111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) chk_idle(k, "after reset");
        end
        @(posedge clk); #1;

        // LATENCY=2: store then load
        access(0, 1, 0, 32'h40, 32'hDEADBEEF, "L2 st 0x40");
        access(0, 0, 1, 32'h40, 32'h0,        "L2 ld 0x40");

        // LATENCY=2: misaligned store is dropped
        access(0, 1, 0, 32'h42, 32'h0BADF00D, "L2 misaligned st");
        access(0, 0, 1, 32'h40, 32'h0,        "L2 ld 0x40 again");

        // LATENCY=1: preload, then back-to-back loads
        access(1, 1, 0, 32'h0, 32'd1, "L1 st 0x0");
        access(1, 1, 0, 32'h4, 32'd2, "L1 st 0x4");
        access(1, 0, 1, 32'h0, 32'd0, "L1 ld 0x0");
        access(1, 0, 1, 32'h4, 32'd0, "L1 ld 0x4");

        // LATENCY=4: reset during WAIT aborts an uncommitted store
        access(2, 1, 0, 32'h80, 32'h11111111, "L4 st 0x80");
        mw[2] = 1; addr[2] = 32'h80; wd[2] = 32'h12345678;
        @(negedge clk);
        chk("L4 abort first stall", {31'd0, stall[2]}, 32'd1);
        @(posedge clk); #1;
        rst[2] = 1'b0;
        #1;
        chk("L4 abort stall", {31'd0, stall[2]}, 32'd0);
        chk("L4 abort done",  {31'd0, done[2]},  32'd0);
        mw[2] = 0;
        mdl_rd[2] = 0;
        @(negedge clk);
        chk("L4 abort rdata", rdata[2], 32'd0);
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(negedge clk);
        chk_idle(2, "L4 after abort");
        @(posedge clk); #1;
        access(2, 0, 1, 32'h80, 32'h0, "L4 ld 0x80");

        // Address wrap and simultaneous read+write
        access(0, 1, 0, 32'h1000, 32'hA5A5A5A5, "L2 st 0x1000");
        access(0, 0, 1, 32'h0,    32'h0,        "L2 ld 0x0 wrap");
        access(0, 1, 1, 32'h8,    32'h1,        "L2 rw 0x8");
        access(0, 0, 1, 32'h8,    32'h0,        "L2 ld 0x8");

        // A few pseudo-random stores and loads on the LATENCY=4 instance
        for (int i = 0; i < 6; i++) begin
            access(2, 1, 0, 32'(i * 4 + 32'h200), $urandom, "L4 rnd st");
        end
        for (int i = 5; i >= 0; i--) begin
            access(2, 0, 1, 32'(i * 4 + 32'h200), 32'h0, "L4 rnd ld");
        end

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
